// File: rtl/compuerta_actuador.sv
// Barrier-side responder: motor FSM with timeout/limit-fault supervision, loop-sensor
// debounce and vehicle-passage pulse. Define CONTEO_VEHICULOS_EN to add the Conteo counter.
module compuerta_actuador #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MOTOR_TIMEOUT   = 64,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Abierto,
  input  logic       Cerrado,
  input  logic       Bloqueo,
  input  logic       Sensor_entrada,
  input  logic       Sensor_salida,
  input  logic       Limite_arriba,
  input  logic       Limite_abajo,
  output logic       Motor_subir,
  output logic       Motor_bajar,
  output logic       Vehiculo,
  output logic       Termino,
  output logic       Falla,
  output logic [2:0] Estado
`ifdef CONTEO_VEHICULOS_EN
  ,
  output logic [15:0] Conteo
`endif
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MOTOR_TIMEOUT - 1);

  typedef enum logic [2:0] {
    CERRADA  = 3'd0,
    SUBIENDO = 3'd1,
    ABIERTA  = 3'd2,
    BAJANDO  = 3'd3,
    FALLA    = 3'd4
  } estado_t;

  estado_t          state;
  estado_t          nxt;
  logic [CNT_W-1:0] ent_cnt;
  logic [CNT_W-1:0] sal_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             ent_f;
  logic             sal_f;
  logic             paso;
  logic             sal_flip;
  logic             sal_rise;
  logic             sal_fall;
  logic             activa;
  logic             pass_done;
  logic             en_movimiento;
  logic             cierre_pedido;

  assign Vehiculo = ent_f;

  // Filtered-exit edge events happen on the same edge the filter toggles
  always_comb begin
    sal_flip      = (Sensor_salida != sal_f) && (sal_cnt == DEB_LAST);
    sal_rise      = sal_flip && !sal_f;
    sal_fall      = sal_flip && sal_f;
    activa        = (state == SUBIENDO) || (state == ABIERTA) || (state == BAJANDO);
    pass_done     = sal_fall && paso;
    en_movimiento = (state == SUBIENDO) || (state == BAJANDO);
    cierre_pedido = Bloqueo || (Cerrado && !Abierto);
  end

  // Debounce: filtered value follows raw only after DEBOUNCE_CYCLES stable samples
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ent_cnt <= '0;
      ent_f   <= 1'b0;
    end else if (Sensor_entrada == ent_f) begin
      ent_cnt <= '0;
    end else if (ent_cnt == DEB_LAST) begin
      ent_cnt <= '0;
      ent_f   <= Sensor_entrada;
    end else begin
      ent_cnt <= ent_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sal_cnt <= '0;
      sal_f   <= 1'b0;
    end else if (Sensor_salida == sal_f) begin
      sal_cnt <= '0;
    end else if (sal_cnt == DEB_LAST) begin
      sal_cnt <= '0;
      sal_f   <= Sensor_salida;
    end else begin
      sal_cnt <= sal_cnt + CNT_W'(1);
    end
  end

  // Next state; contradictory limit switches override every state
  always_comb begin
    nxt = state;
    if (Limite_arriba && Limite_abajo) begin
      nxt = FALLA;
    end else begin
      case (state)
        CERRADA: begin
          if (Abierto && !Bloqueo) nxt = SUBIENDO;
        end
        SUBIENDO: begin
          if (Limite_arriba)            nxt = ABIERTA;
          else if (tmo_cnt == TMO_LAST) nxt = FALLA;
        end
        ABIERTA: begin
          if (cierre_pedido && !ent_f && !sal_f) nxt = BAJANDO;
        end
        BAJANDO: begin
          if (ent_f || sal_f)           nxt = SUBIENDO;
          else if (Limite_abajo)        nxt = CERRADA;
          else if (tmo_cnt == TMO_LAST) nxt = FALLA;
        end
        FALLA:   nxt = FALLA;
        default: nxt = FALLA;
      endcase
    end
  end

  // State, timeout, passage tracking and outputs decoded from the state being entered
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= CERRADA;
      tmo_cnt     <= '0;
      paso        <= 1'b0;
      Motor_subir <= 1'b0;
      Motor_bajar <= 1'b0;
      Falla       <= 1'b0;
      Termino     <= 1'b0;
      Estado      <= 3'd0;
    end else begin
      state       <= nxt;
      Estado      <= nxt;
      Motor_subir <= (nxt == SUBIENDO);
      Motor_bajar <= (nxt == BAJANDO);
      Falla       <= (nxt == FALLA);
      Termino     <= pass_done;

      if (nxt != state)    tmo_cnt <= '0;
      else if (en_movimiento) tmo_cnt <= tmo_cnt + CNT_W'(1);
      else                 tmo_cnt <= '0;

      if ((nxt != state) && ((nxt == CERRADA) || (nxt == FALLA))) paso <= 1'b0;
      else if (pass_done)                                          paso <= 1'b0;
      else if (sal_rise && activa)                                 paso <= 1'b1;
    end
  end

`ifdef CONTEO_VEHICULOS_EN
  // Passage counter, wraps naturally at 16 bits
  always_ff @(posedge Clk) begin
    if (Reset)          Conteo <= 16'd0;
    else if (pass_done) Conteo <= Conteo + 16'd1;
  end
`endif

endmodule

// File: tb/tb_compuerta_actuador.sv
// Directed bench for compuerta_actuador: FSM sequencing, debounce, passage pulse,
// timeout and limit faults; checks Conteo when CONTEO_VEHICULOS_EN is defined.
module tb_compuerta_actuador;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Abierto, Cerrado, Bloqueo;
  logic       Sensor_entrada, Sensor_salida;
  logic       Limite_arriba, Limite_abajo;
  logic       Motor_subir, Motor_bajar, Vehiculo, Termino, Falla;
  logic [2:0] Estado;
`ifdef CONTEO_VEHICULOS_EN
  logic [15:0] Conteo;
`endif

  // {Motor_subir, Motor_bajar, Falla, Estado}
  localparam logic [5:0] S_CER = 6'b000_000;
  localparam logic [5:0] S_SUB = 6'b100_001;
  localparam logic [5:0] S_ABI = 6'b000_010;
  localparam logic [5:0] S_BAJ = 6'b010_011;
  localparam logic [5:0] S_FAL = 6'b001_100;

  logic [5:0] obs;
  assign obs = {Motor_subir, Motor_bajar, Falla, Estado};

  int n_tests = 0;
  int n_fail  = 0;

  compuerta_actuador dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Abierto        (Abierto),
    .Cerrado        (Cerrado),
    .Bloqueo        (Bloqueo),
    .Sensor_entrada (Sensor_entrada),
    .Sensor_salida  (Sensor_salida),
    .Limite_arriba  (Limite_arriba),
    .Limite_abajo   (Limite_abajo),
    .Motor_subir    (Motor_subir),
    .Motor_bajar    (Motor_bajar),
    .Vehiculo       (Vehiculo),
    .Termino        (Termino),
    .Falla          (Falla),
    .Estado         (Estado)
`ifdef CONTEO_VEHICULOS_EN
    ,
    .Conteo         (Conteo)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_inputs();
    Abierto = 0; Cerrado = 0; Bloqueo = 0;
    Sensor_entrada = 0; Sensor_salida = 0;
    Limite_arriba = 0; Limite_abajo = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset = 1;
    ticks(2);
    Reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    Abierto = 1;
    Reset = 1;
    ticks(2);
    n_tests++;
    if (obs !== S_CER) begin n_fail++; $display("FAIL reset_state: got %b expected %b", obs, S_CER); end
    n_tests++;
    if ({Vehiculo, Termino} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00", {Vehiculo, Termino});
    end
    Reset = 0;
    Abierto = 0;
  endtask

  task automatic test_open();
    do_reset();
    Abierto = 1;
    tick();
    n_tests++;
    if (obs !== S_SUB) begin n_fail++; $display("FAIL open_subiendo: got %b expected %b", obs, S_SUB); end
    ticks(8);
    n_tests++;
    if (obs !== S_SUB) begin n_fail++; $display("FAIL open_hold: got %b expected %b", obs, S_SUB); end
    Limite_arriba = 1;
    tick();
    n_tests++;
    if (obs !== S_ABI) begin n_fail++; $display("FAIL open_abierta: got %b expected %b", obs, S_ABI); end
    Abierto = 0;
  endtask

  task automatic test_passage();
    int pulses = 0;
    int first  = -1;
    Sensor_salida = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (Termino) pulses++;
    end
    Sensor_salida = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (Termino) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL passage_count: got %0d expected 1", pulses); end
    n_tests++;
    if (first != 4) begin n_fail++; $display("FAIL passage_latency: got %0d expected 4", first); end
    n_tests++;
    if (obs !== S_ABI) begin n_fail++; $display("FAIL passage_state: got %b expected %b", obs, S_ABI); end
  endtask

  task automatic test_glitch();
    int seen = 0;
    Sensor_entrada = 1;
    for (int i = 0; i < 2; i++) begin tick(); if (Vehiculo || Termino) seen++; end
    Sensor_entrada = 0;
    Sensor_salida  = 1;
    for (int i = 0; i < 2; i++) begin tick(); if (Vehiculo || Termino) seen++; end
    Sensor_salida = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (Vehiculo || Termino) seen++; end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL glitch_blocked: got %0d events expected 0", seen); end
    Sensor_entrada = 1;
    ticks(3);
    n_tests++;
    if (Vehiculo !== 1'b0) begin n_fail++; $display("FAIL deb_three: got %b expected 0", Vehiculo); end
    tick();
    n_tests++;
    if (Vehiculo !== 1'b1) begin n_fail++; $display("FAIL deb_four: got %b expected 1", Vehiculo); end
    Sensor_entrada = 0;
    ticks(4);
    n_tests++;
    if (Vehiculo !== 1'b0) begin n_fail++; $display("FAIL deb_fall: got %b expected 0", Vehiculo); end
  endtask

  task automatic test_reverse();
    Cerrado = 1;
    Limite_arriba = 0;
    tick();
    n_tests++;
    if (obs !== S_BAJ) begin n_fail++; $display("FAIL close_bajando: got %b expected %b", obs, S_BAJ); end
    Sensor_entrada = 1;
    ticks(4);
    n_tests++;
    if ({Vehiculo, obs} !== {1'b1, S_BAJ}) begin
      n_fail++; $display("FAIL reverse_pre: got %b expected %b", {Vehiculo, obs}, {1'b1, S_BAJ});
    end
    tick();
    n_tests++;
    if (obs !== S_SUB) begin n_fail++; $display("FAIL reverse_subiendo: got %b expected %b", obs, S_SUB); end
    Sensor_entrada = 0;
    Cerrado = 0;
    Limite_arriba = 1;
    tick();
    ticks(4);
    n_tests++;
    if ({Vehiculo, obs} !== {1'b0, S_ABI}) begin
      n_fail++; $display("FAIL reverse_reopen: got %b expected %b", {Vehiculo, obs}, {1'b0, S_ABI});
    end
    Abierto = 1;
    Cerrado = 1;
    ticks(3);
    n_tests++;
    if (obs !== S_ABI) begin n_fail++; $display("FAIL open_wins: got %b expected %b", obs, S_ABI); end
    Abierto = 0;
    tick();
    n_tests++;
    if (obs !== S_BAJ) begin n_fail++; $display("FAIL close_again: got %b expected %b", obs, S_BAJ); end
    Limite_arriba = 0;
    ticks(3);
    Limite_abajo = 1;
    tick();
    n_tests++;
    if (obs !== S_CER) begin n_fail++; $display("FAIL close_done: got %b expected %b", obs, S_CER); end
    Cerrado = 0;
  endtask

  task automatic test_bloqueo();
    do_reset();
    Limite_abajo = 1;
    Bloqueo = 1;
    Abierto = 1;
    ticks(3);
    n_tests++;
    if (obs !== S_CER) begin n_fail++; $display("FAIL bloqueo_hold: got %b expected %b", obs, S_CER); end
    Bloqueo = 0;
    tick();
    Limite_abajo = 0;
    Limite_arriba = 1;
    tick();
    n_tests++;
    if (obs !== S_ABI) begin n_fail++; $display("FAIL bloqueo_open: got %b expected %b", obs, S_ABI); end
    Bloqueo = 1;
    tick();
    n_tests++;
    if (obs !== S_BAJ) begin n_fail++; $display("FAIL bloqueo_close: got %b expected %b", obs, S_BAJ); end
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    Abierto = 1;
    tick();
    ticks(63);
    n_tests++;
    if (obs !== S_SUB) begin n_fail++; $display("FAIL timeout_before: got %b expected %b", obs, S_SUB); end
    tick();
    n_tests++;
    if (obs !== S_FAL) begin n_fail++; $display("FAIL timeout_falla: got %b expected %b", obs, S_FAL); end
    for (int i = 0; i < 5; i++) begin Abierto = ~Abierto; tick(); end
    n_tests++;
    if (obs !== S_FAL) begin n_fail++; $display("FAIL falla_sticky: got %b expected %b", obs, S_FAL); end
    Abierto = 0;
    Reset = 1;
    tick();
    Reset = 0;
    n_tests++;
    if (obs !== S_CER) begin n_fail++; $display("FAIL falla_reset: got %b expected %b", obs, S_CER); end
  endtask

  task automatic test_faults_and_reset();
    do_reset();
    Limite_arriba = 1;
    Limite_abajo = 1;
    tick();
    n_tests++;
    if (obs !== S_FAL) begin n_fail++; $display("FAIL both_limits: got %b expected %b", obs, S_FAL); end
    do_reset();
    Abierto = 1;
    tick();
    Reset = 1;
    tick();
    Reset = 0;
    Abierto = 0;
    n_tests++;
    if (obs !== S_CER) begin n_fail++; $display("FAIL reset_midmotion: got %b expected %b", obs, S_CER); end
  endtask

  task automatic test_no_paso_closed();
    int pulses = 0;
    do_reset();
    Sensor_salida = 1;
    ticks(6);
    Sensor_salida = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (Termino) pulses++; end
    n_tests++;
    if (pulses != 0) begin n_fail++; $display("FAIL closed_no_termino: got %0d expected 0", pulses); end
  endtask

`ifdef CONTEO_VEHICULOS_EN
  task automatic test_conteo();
    do_reset();
    Abierto = 1;
    tick();
    Limite_arriba = 1;
    tick();
    Abierto = 0;
    for (int p = 0; p < 3; p++) begin
      Sensor_salida = 1;
      ticks(6);
      Sensor_salida = 0;
      ticks(6);
    end
    n_tests++;
    if (Conteo !== 16'd3) begin n_fail++; $display("FAIL conteo_three: got %0d expected 3", Conteo); end
    Reset = 1;
    tick();
    Reset = 0;
    n_tests++;
    if (Conteo !== 16'd0) begin n_fail++; $display("FAIL conteo_reset: got %0d expected 0", Conteo); end
    clear_inputs();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    Reset = 1;
    test_reset();
    test_open();
    test_passage();
    test_glitch();
    test_reverse();
    test_bloqueo();
    test_timeout();
    test_faults_and_reset();
    test_no_paso_closed();
`ifdef CONTEO_VEHICULOS_EN
    test_conteo();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
